// File: rtl/ame_equation_accum_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ame_equation_accum_pkg                                                     |
// | Shared constants, state encoding and index helpers for the equation accum. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package ame_equation_accum_pkg;

    localparam int C_N_COEF = 6;
    localparam int C_N_TRI  = 21;

    typedef logic [2:0] state_t;

    localparam state_t C_ST_IDLE  = 3'd0;
    localparam state_t C_ST_ACCUM = 3'd1;
    localparam state_t C_ST_DRAIN = 3'd2;
    localparam state_t C_ST_ISSUE = 3'd3;
    localparam state_t C_ST_WAIT  = 3'd4;

    // Last DRAIN count value; the final S3 update lands before ISSUE.
    localparam logic [1:0] C_DRAIN_LAST = 2'd2;

    function automatic int coef_bits(input int grad_bits, input int pos_bits);
        return grad_bits + pos_bits + 2;
    endfunction

    localparam int COEF_BITS = coef_bits(16, 7);

    // Row-major packing of the upper triangle (j >= i) of a 6x6 matrix.
    function automatic int tri_idx(input int i, input int j);
        return i * C_N_COEF - (i * (i - 1)) / 2 + (j - i);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ame_equation_accum_coef_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ame_equation_accum_coef_gen                                                |
// | S1 stage: registers the sample and its mode-dependent coefficients c0..c5. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ame_equation_accum_coef_gen
    import ame_equation_accum_pkg::*;
#(
    parameter int GRAD_BITS = 16,
    parameter int DIFF_BITS = 16,
    parameter int POS_BITS  = 7,
    parameter int COEF_W    = 25
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          valid_i,
    input  logic                          mode6_i,
    input  logic [GRAD_BITS-1:0]          gx_i,
    input  logic [GRAD_BITS-1:0]          gy_i,
    input  logic [POS_BITS-1:0]           x_i,
    input  logic [POS_BITS-1:0]           y_i,
    input  logic [DIFF_BITS-1:0]          diff_i,
    output logic                          valid_o,
    output logic [DIFF_BITS-1:0]          diff_o,
    output logic [C_N_COEF-1:0][COEF_W-1:0] coef_o
);

    logic [COEF_W-1:0] w_gx, w_gy, w_x, w_y;
    logic [COEF_W-1:0] w_xgx, w_ygy, w_ygx, w_xgy;
    logic [C_N_COEF-1:0][COEF_W-1:0] w_coef;

    // Operands are extended to the full coefficient width, so the truncated
    // product holds the exact signed result.
    assign w_gx  = {{(COEF_W-GRAD_BITS){gx_i[GRAD_BITS-1]}}, gx_i};
    assign w_gy  = {{(COEF_W-GRAD_BITS){gy_i[GRAD_BITS-1]}}, gy_i};
    assign w_x   = {{(COEF_W-POS_BITS){1'b0}}, x_i};
    assign w_y   = {{(COEF_W-POS_BITS){1'b0}}, y_i};
    assign w_xgx = w_x * w_gx;
    assign w_ygy = w_y * w_gy;
    assign w_ygx = w_y * w_gx;
    assign w_xgy = w_x * w_gy;

    always_comb begin
        w_coef = '0;
        if (mode6_i) begin
            w_coef[0] = w_gx;
            w_coef[1] = w_xgx;
            w_coef[2] = w_gy;
            w_coef[3] = w_ygy;
            w_coef[4] = w_ygx;
            w_coef[5] = w_xgy;
        end else begin
            w_coef[2] = w_gx;
            w_coef[3] = w_xgx + w_ygy;
            w_coef[4] = w_gy;
            w_coef[5] = w_xgy - w_ygx;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_o <= 1'b0;
            diff_o  <= '0;
            coef_o  <= '0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                diff_o <= diff_i;
                coef_o <= w_coef;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ame_equation_accum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ame_equation_accum                                                         |
// | Accumulates affine ME normal equations A += c c^T, B += c diff per block.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ame_equation_accum
    import ame_equation_accum_pkg::*;
#(
    parameter int GRAD_BITS      = 16,
    parameter int DIFF_BITS      = 16,
    parameter int POS_BITS       = 7,
    parameter int COMP_DATA_BITS = 64
) (
    input  logic                                clk_i,
    input  logic                                rst_n_i,
    input  logic                                start_i,
    input  logic                                affine_param6_i,
    input  logic                                samp_valid_i,
    output logic                                samp_ready_o,
    input  logic                                samp_last_i,
    input  logic [GRAD_BITS-1:0]                samp_gx_i,
    input  logic [GRAD_BITS-1:0]                samp_gy_i,
    input  logic [POS_BITS-1:0]                 samp_x_i,
    input  logic [POS_BITS-1:0]                 samp_y_i,
    input  logic [DIFF_BITS-1:0]                samp_diff_i,
    output logic                                comp_init_o,
    input  logic                                comp_done_i,
    output logic                                affine_param6_o,
    output logic [5:0][6:0][COMP_DATA_BITS-1:0] comp_data_o
);

    localparam int C_CW   = coef_bits(GRAD_BITS, POS_BITS);
    localparam int C_PA_W = 2 * C_CW;
    localparam int C_PB_W = C_CW + DIFF_BITS;

    state_t     r_state;
    logic [1:0] r_drain_cnt;
    logic       r_mode;
    logic       w_accept;
    logic       w_start;

    logic                           w_s1_valid;
    logic [DIFF_BITS-1:0]           w_s1_diff;
    logic [C_N_COEF-1:0][C_CW-1:0]  w_s1_coef;

    logic [C_PA_W-1:0]         w_prod_a [C_N_TRI];
    logic [C_PB_W-1:0]         w_prod_b [C_N_COEF];
    logic [C_PA_W-1:0]         r_prod_a [C_N_TRI];
    logic [C_PB_W-1:0]         r_prod_b [C_N_COEF];
    logic                      r_s2_valid;
    logic [COMP_DATA_BITS-1:0] r_acc_a  [C_N_TRI];
    logic [COMP_DATA_BITS-1:0] r_acc_b  [C_N_COEF];

    assign samp_ready_o    = (r_state == C_ST_ACCUM);
    assign comp_init_o     = (r_state == C_ST_ISSUE);
    assign affine_param6_o = r_mode;
    assign w_accept        = samp_valid_i & samp_ready_o;
    assign w_start         = (r_state == C_ST_IDLE) & start_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= C_ST_IDLE;
            r_drain_cnt <= '0;
            r_mode      <= 1'b0;
        end else begin
            case (r_state)
                C_ST_IDLE: if (start_i) begin
                    r_state <= C_ST_ACCUM;
                    r_mode  <= affine_param6_i;
                end
                C_ST_ACCUM: if (w_accept && samp_last_i) begin
                    r_state     <= C_ST_DRAIN;
                    r_drain_cnt <= '0;
                end
                C_ST_DRAIN: begin
                    if (r_drain_cnt == C_DRAIN_LAST) r_state <= C_ST_ISSUE;
                    else                             r_drain_cnt <= r_drain_cnt + 2'd1;
                end
                C_ST_ISSUE: r_state <= C_ST_WAIT;
                C_ST_WAIT:  if (comp_done_i) r_state <= C_ST_IDLE;
                default:    r_state <= C_ST_IDLE;
            endcase
        end
    end

    ame_equation_accum_coef_gen #(
        .GRAD_BITS (GRAD_BITS),
        .DIFF_BITS (DIFF_BITS),
        .POS_BITS  (POS_BITS),
        .COEF_W    (C_CW)
    ) u_coef_gen (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .valid_i (w_accept),
        .mode6_i (r_mode),
        .gx_i    (samp_gx_i),
        .gy_i    (samp_gy_i),
        .x_i     (samp_x_i),
        .y_i     (samp_y_i),
        .diff_i  (samp_diff_i),
        .valid_o (w_s1_valid),
        .diff_o  (w_s1_diff),
        .coef_o  (w_s1_coef)
    );

    // Sign-extended to the product width; the low bits of the product are then
    // the exact two's-complement result.
    always_comb begin
        for (int k = 0; k < C_N_TRI; k++) w_prod_a[k] = '0;
        for (int i = 0; i < C_N_COEF; i++) begin
            for (int j = i; j < C_N_COEF; j++) begin
                w_prod_a[tri_idx(i, j)] =
                    {{C_CW{w_s1_coef[i][C_CW-1]}}, w_s1_coef[i]} *
                    {{C_CW{w_s1_coef[j][C_CW-1]}}, w_s1_coef[j]};
            end
        end
        for (int i = 0; i < C_N_COEF; i++) begin
            w_prod_b[i] = {{DIFF_BITS{w_s1_coef[i][C_CW-1]}}, w_s1_coef[i]} *
                          {{C_CW{w_s1_diff[DIFF_BITS-1]}}, w_s1_diff};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_s2_valid <= 1'b0;
            for (int k = 0; k < C_N_TRI; k++)  r_prod_a[k] <= '0;
            for (int k = 0; k < C_N_COEF; k++) r_prod_b[k] <= '0;
        end else begin
            r_s2_valid <= w_s1_valid;
            if (w_s1_valid) begin
                for (int k = 0; k < C_N_TRI; k++)  r_prod_a[k] <= w_prod_a[k];
                for (int k = 0; k < C_N_COEF; k++) r_prod_b[k] <= w_prod_b[k];
            end
        end
    end

    // Accumulation wraps modulo 2^COMP_DATA_BITS.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < C_N_TRI; k++)  r_acc_a[k] <= '0;
            for (int k = 0; k < C_N_COEF; k++) r_acc_b[k] <= '0;
        end else if (w_start) begin
            for (int k = 0; k < C_N_TRI; k++)  r_acc_a[k] <= '0;
            for (int k = 0; k < C_N_COEF; k++) r_acc_b[k] <= '0;
        end else if (r_s2_valid) begin
            for (int k = 0; k < C_N_TRI; k++)
                r_acc_a[k] <= r_acc_a[k] +
                    {{(COMP_DATA_BITS-C_PA_W){r_prod_a[k][C_PA_W-1]}}, r_prod_a[k]};
            for (int k = 0; k < C_N_COEF; k++)
                r_acc_b[k] <= r_acc_b[k] +
                    {{(COMP_DATA_BITS-C_PB_W){r_prod_b[k][C_PB_W-1]}}, r_prod_b[k]};
        end
    end

    always_comb begin
        comp_data_o = '0;
        for (int i = 0; i < C_N_COEF; i++) begin
            for (int j = 0; j < C_N_COEF; j++) begin
                comp_data_o[i][j] = (j >= i) ? r_acc_a[tri_idx(i, j)] : r_acc_a[tri_idx(j, i)];
            end
            comp_data_o[i][6] = r_acc_b[i];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ame_equation_accum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ame_equation_accum                                                      |
// | Self-checking bench against a full-matrix arithmetic model.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ame_equation_accum;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mode_in = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        comp_done = 1'b0;
    logic [15:0] gx = '0, gy = '0, diff = '0;
    logic [6:0]  sx = '0, sy = '0;
    logic        samp_ready, comp_init, param6_o;
    logic [5:0][6:0][63:0] cdata;

    ame_equation_accum dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .start_i         (start),
        .affine_param6_i (mode_in),
        .samp_valid_i    (s_valid),
        .samp_ready_o    (samp_ready),
        .samp_last_i     (s_last),
        .samp_gx_i       (gx),
        .samp_gy_i       (gy),
        .samp_x_i        (sx),
        .samp_y_i        (sy),
        .samp_diff_i     (diff),
        .comp_init_o     (comp_init),
        .comp_done_i     (comp_done),
        .affine_param6_o (param6_o),
        .comp_data_o     (cdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int init_total = 0;
    int errors = 0;
    int checks = 0;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (comp_init) init_total++;

    longint m_a [6][6];
    longint m_b [6];
    int q_gx[$], q_gy[$], q_x[$], q_y[$], q_d[$];

    task automatic model_clear();
        for (int i = 0; i < 6; i++) begin
            m_b[i] = 0;
            for (int j = 0; j < 6; j++) m_a[i][j] = 0;
        end
        q_gx.delete(); q_gy.delete(); q_x.delete(); q_y.delete(); q_d.delete();
    endtask

    // Full symmetric normal equations computed directly from the coefficient rules.
    task automatic push_sample(input bit m, input int g_x, input int g_y,
                               input int px, input int py, input int d);
        longint c[6];
        longint lgx = g_x, lgy = g_y, lx = px, ly = py, ld = d;
        q_gx.push_back(g_x); q_gy.push_back(g_y);
        q_x.push_back(px); q_y.push_back(py); q_d.push_back(d);
        if (m) begin
            c[0] = lgx; c[1] = lx * lgx; c[2] = lgy;
            c[3] = ly * lgy; c[4] = ly * lgx; c[5] = lx * lgy;
        end else begin
            c[0] = 0; c[1] = 0; c[2] = lgx;
            c[3] = lx * lgx + ly * lgy; c[4] = lgy; c[5] = lx * lgy - ly * lgx;
        end
        for (int i = 0; i < 6; i++) begin
            m_b[i] += c[i] * ld;
            for (int j = 0; j < 6; j++) m_a[i][j] += c[i] * c[j];
        end
    endtask

    // Starts a block and streams the queued samples; reports comp_init latency
    // relative to the cycle the last sample was accepted (-1 when comp_init never rises).
    task automatic run_block(input bit m, input int gap_pct, output int lat,
                             output int inits, output int ready_hi);
        int k, n, guard, t_last;
        bit rdy;
        n = q_gx.size(); lat = -1; inits = 0; ready_hi = 0; k = 0; guard = 0; t_last = 0;
        start = 1'b1; mode_in = m;
        @(posedge clk); #1;
        start = 1'b0; mode_in = ~m;
        while (k < n && guard < 40 * n + 100) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                s_valid = 1'b0; s_last = 1'b0;
            end else begin
                s_valid = 1'b1;
                gx = 16'(q_gx[k]); gy = 16'(q_gy[k]);
                sx = 7'(q_x[k]);   sy = 7'(q_y[k]);
                diff = 16'(q_d[k]);
                s_last = (k == n - 1);
            end
            rdy = samp_ready;
            if (s_valid && s_last && rdy) t_last = cyc;
            @(posedge clk); #1;
            if (s_valid && rdy) k++;
            guard++;
        end
        s_valid = 1'b0; s_last = 1'b0;
        if (k < n) return;
        for (int c = 0; c < 12; c++) begin
            if (comp_init) begin
                inits++;
                if (lat < 0) lat = cyc - t_last;
            end
            if (samp_ready) ready_hi++;
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_done();
        comp_done = 1'b1;
        @(posedge clk); #1;
        comp_done = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        checks++; if (samp_ready !== 1'b0) begin errors++; $display("FAIL reset ready got %b expected 0", samp_ready); end
        checks++; if (comp_init !== 1'b0) begin errors++; $display("FAIL reset comp_init got %b expected 0", comp_init); end
        checks++; if (param6_o !== 1'b0) begin errors++; $display("FAIL reset param6 got %b expected 0", param6_o); end
        checks++; if (cdata !== '0) begin errors++; $display("FAIL reset data got nonzero expected 0"); end
    endtask

    task automatic test_6p_single();
        int lat, inits, rh;
        model_clear();
        push_sample(1'b1, 1, 0, 2, 3, 5);
        run_block(1'b1, 0, lat, inits, rh);
        checks++; if (lat !== 4) begin errors++; $display("FAIL 6p latency got %0d expected 4", lat); end
        checks++; if (inits !== 1) begin errors++; $display("FAIL 6p init_pulses got %0d expected 1", inits); end
        checks++; if (cdata[0][4] !== 64'd3 || cdata[4][0] !== 64'd3) begin
            errors++; $display("FAIL 6p A04/A40 got %0d/%0d expected 3", cdata[0][4], cdata[4][0]); end
        checks++; if (cdata[4][4] !== 64'd9) begin errors++; $display("FAIL 6p A44 got %0d expected 9", cdata[4][4]); end
        checks++; if (cdata[1][6] !== 64'd10) begin errors++; $display("FAIL 6p B1 got %0d expected 10", cdata[1][6]); end
        checks++; if (param6_o !== 1'b1) begin errors++; $display("FAIL 6p param6 got %b expected 1", param6_o); end
        for (int i = 0; i < 6; i++) for (int j = 0; j < 7; j++) begin
            longint e = (j < 6) ? m_a[i][j] : m_b[i];
            checks++;
            if (cdata[i][j] !== e) begin errors++;
                $display("FAIL 6p data[%0d][%0d] got %0d expected %0d", i, j, $signed(cdata[i][j]), e); end
        end
        pulse_done();
    endtask

    task automatic test_4p_single();
        int lat, inits, rh;
        model_clear();
        push_sample(1'b0, 1, 2, 3, 1, -1);
        run_block(1'b0, 0, lat, inits, rh);
        checks++; if (lat !== 4) begin errors++; $display("FAIL 4p latency got %0d expected 4", lat); end
        checks++; if (cdata[3][3] !== 64'd25) begin errors++; $display("FAIL 4p A33 got %0d expected 25", cdata[3][3]); end
        checks++; if (cdata[5][2] !== 64'd5) begin errors++; $display("FAIL 4p A52 got %0d expected 5", cdata[5][2]); end
        checks++; if (cdata[3][6] !== 64'hFFFF_FFFF_FFFF_FFFB) begin
            errors++; $display("FAIL 4p B3 got %0d expected -5", $signed(cdata[3][6])); end
        checks++; if (param6_o !== 1'b0) begin errors++; $display("FAIL 4p param6 got %b expected 0", param6_o); end
        for (int i = 0; i < 6; i++) for (int j = 0; j < 7; j++) begin
            longint e = (j < 6) ? m_a[i][j] : m_b[i];
            checks++;
            if (cdata[i][j] !== e) begin errors++;
                $display("FAIL 4p data[%0d][%0d] got %0d expected %0d", i, j, $signed(cdata[i][j]), e); end
        end
        pulse_done();
    endtask

    task automatic test_block_16x16();
        int lat, inits, rh;
        model_clear();
        for (int y = 0; y < 16; y++) for (int x = 0; x < 16; x++) push_sample(1'b1, -1, -1, x, y, 2);
        run_block(1'b1, 30, lat, inits, rh);
        checks++; if (lat !== 4) begin errors++; $display("FAIL blk16 latency got %0d expected 4", lat); end
        checks++; if (inits !== 1) begin errors++; $display("FAIL blk16 init_pulses got %0d expected 1", inits); end
        checks++; if (rh !== 0) begin errors++; $display("FAIL blk16 ready_after_last got %0d cycles expected 0", rh); end
        for (int i = 0; i < 6; i++) for (int j = 0; j < 7; j++) begin
            longint e = (j < 6) ? m_a[i][j] : m_b[i];
            checks++;
            if (cdata[i][j] !== e) begin errors++;
                $display("FAIL blk16 data[%0d][%0d] got %0d expected %0d", i, j, $signed(cdata[i][j]), e); end
        end
        pulse_done();
        checks++; if (samp_ready !== 1'b0) begin errors++; $display("FAIL blk16 idle_ready got %b expected 0", samp_ready); end
    endtask

    task automatic test_random(input int n_blocks);
        int lat, inits, rh;
        bit m;
        for (int b = 0; b < n_blocks; b++) begin
            model_clear();
            m = 1'($urandom_range(1));
            for (int s = 0; s < 40; s++)
                push_sample(m, int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768,
                            int'($urandom_range(127)), int'($urandom_range(127)),
                            int'($urandom_range(65535)) - 32768);
            run_block(m, 20, lat, inits, rh);
            checks++; if (lat !== 4 || rh !== 0) begin errors++;
                $display("FAIL rand%0d latency/ready got %0d/%0d expected 4/0", b, lat, rh); end
            for (int i = 0; i < 6; i++) for (int j = 0; j < 7; j++) begin
                longint e = (j < 6) ? m_a[i][j] : m_b[i];
                checks++;
                if (cdata[i][j] !== e) begin errors++;
                    $display("FAIL rand%0d data[%0d][%0d] got %0d expected %0d", b, i, j, $signed(cdata[i][j]), e); end
            end
            pulse_done();
        end
    endtask

    task automatic test_extreme(input bit m);
        int lat, inits, rh;
        model_clear();
        for (int s = 0; s < 16384; s++) push_sample(m, -32768, -32768, 127, 127, -32768);
        run_block(m, 0, lat, inits, rh);
        checks++; if (lat !== 4) begin errors++; $display("FAIL extreme%0d latency got %0d expected 4", m, lat); end
        for (int i = 0; i < 6; i++) for (int j = 0; j < 7; j++) begin
            longint e = (j < 6) ? m_a[i][j] : m_b[i];
            checks++;
            if (cdata[i][j] !== e) begin errors++;
                $display("FAIL extreme%0d data[%0d][%0d] got %0d expected %0d", m, i, j, $signed(cdata[i][j]), e); end
        end
        pulse_done();
    endtask

    task automatic test_ignored_ctrl();
        int t_last, n, base, lat, inits, rh;
        model_clear();
        push_sample(1'b1, 7, -3, 5, 9, 11);
        push_sample(1'b1, -2, 4, 100, 20, -6);
        start = 1'b1; mode_in = 1'b1;
        @(posedge clk); #1;
        // Illegal start (with other mode) and done alongside the first sample.
        s_valid = 1'b1; s_last = 1'b0;
        gx = 16'(q_gx[0]); gy = 16'(q_gy[0]); sx = 7'(q_x[0]); sy = 7'(q_y[0]); diff = 16'(q_d[0]);
        start = 1'b1; mode_in = 1'b0; comp_done = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; comp_done = 1'b0;
        s_last = 1'b1;
        gx = 16'(q_gx[1]); gy = 16'(q_gy[1]); sx = 7'(q_x[1]); sy = 7'(q_y[1]); diff = 16'(q_d[1]);
        t_last = cyc;
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
        n = 0;
        while (!comp_init && n < 12) begin @(posedge clk); #1; n++; end
        checks++; if (!comp_init || cyc - t_last !== 4) begin errors++;
            $display("FAIL ctrl latency got %0d expected 4", comp_init ? cyc - t_last : -1); end
        base = init_total + 1;
        comp_done = 1'b1;
        @(posedge clk); #1;
        comp_done = 1'b0; start = 1'b1; mode_in = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (samp_ready !== 1'b0) begin errors++; $display("FAIL ctrl wait_ready got %b expected 0", samp_ready); end
        checks++; if (param6_o !== 1'b1) begin errors++; $display("FAIL ctrl held_mode got %b expected 1", param6_o); end
        checks++; if (init_total !== base) begin errors++; $display("FAIL ctrl init_count got %0d expected %0d", init_total, base); end
        for (int i = 0; i < 6; i++) for (int j = 0; j < 7; j++) begin
            longint e = (j < 6) ? m_a[i][j] : m_b[i];
            checks++;
            if (cdata[i][j] !== e) begin errors++;
                $display("FAIL ctrl held_data[%0d][%0d] got %0d expected %0d", i, j, $signed(cdata[i][j]), e); end
        end
        pulse_done();
        checks++; if (samp_ready !== 1'b0 || cdata[0][0] !== 64'(m_a[0][0])) begin errors++;
            $display("FAIL ctrl idle_retain ready=%b A00=%0d expected 0/%0d", samp_ready, cdata[0][0], m_a[0][0]); end
        model_clear();
        push_sample(1'b0, 300, -40, 17, 60, 9);
        run_block(1'b0, 0, lat, inits, rh);
        checks++; if (lat !== 4 || param6_o !== 1'b0) begin errors++;
            $display("FAIL ctrl restart latency/mode got %0d/%b expected 4/0", lat, param6_o); end
        checks++; if (cdata[3][5] !== 64'(m_a[5][3]) || cdata[4][6] !== 64'(m_b[4])) begin errors++;
            $display("FAIL ctrl restart A35/B4 got %0d/%0d expected %0d/%0d",
                     $signed(cdata[3][5]), $signed(cdata[4][6]), m_a[5][3], m_b[4]); end
        pulse_done();
    endtask

    task automatic test_async_reset();
        int base, lat, inits, rh;
        model_clear();
        start = 1'b1; mode_in = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int s = 0; s < 5; s++) begin
            s_valid = 1'b1; gx = 16'(1000 + s); gy = 16'(s); sx = 7'(s + 3); sy = 7'(s); diff = 16'(50);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        base = init_total;
        checks++; if (samp_ready !== 1'b0 || comp_init !== 1'b0 || param6_o !== 1'b0) begin errors++;
            $display("FAIL arst outputs ready=%b init=%b mode=%b expected 0", samp_ready, comp_init, param6_o); end
        checks++; if (cdata !== '0) begin errors++; $display("FAIL arst data got nonzero expected 0"); end
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        repeat (10) begin @(posedge clk); #1; end
        checks++; if (init_total !== base) begin errors++;
            $display("FAIL arst spurious_init got %0d expected %0d", init_total, base); end
        for (int s = 0; s < 8; s++)
            push_sample(1'b1, int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768,
                        int'($urandom_range(127)), int'($urandom_range(127)), int'($urandom_range(65535)) - 32768);
        run_block(1'b1, 10, lat, inits, rh);
        checks++; if (lat !== 4) begin errors++; $display("FAIL arst next_latency got %0d expected 4", lat); end
        for (int i = 0; i < 6; i++) for (int j = 0; j < 7; j++) begin
            longint e = (j < 6) ? m_a[i][j] : m_b[i];
            checks++;
            if (cdata[i][j] !== e) begin errors++;
                $display("FAIL arst next_data[%0d][%0d] got %0d expected %0d", i, j, $signed(cdata[i][j]), e); end
        end
        pulse_done();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_6p_single();
        test_4p_single();
        test_block_16x16();
        test_random(4);
        test_extreme(1'b1);
        test_extreme(1'b0);
        test_ignored_ctrl();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
